// File: rtl/multibus_pkg.sv
// Shared definitions for the multibus configuration sequencer.
package multibus_pkg;

  localparam int MB_REG_COUNT = 16;
  localparam int MB_ADDR_W    = 4;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } mb_state_e;

  // Increment a register index, wrapping explicitly at count so a
  // non-power-of-two bank never yields an out-of-range index.
  function automatic int next_index(input int idx, input int count = MB_REG_COUNT);
    return (idx + 1 >= count) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/multibus_rr_pick.sv
// Rotating-priority finder: first pending index at or after ptr, wrapping.
module multibus_rr_pick
  import multibus_pkg::*;
#(
  parameter int REG_COUNT = MB_REG_COUNT,
  parameter int ADDR_W    = MB_ADDR_W
) (
  input  logic [REG_COUNT-1:0] pending,
  input  logic [ADDR_W-1:0]    ptr,
  output logic                 found,
  output logic [ADDR_W-1:0]    idx
);

  // Walk the bank starting at ptr and keep the first pending hit.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < REG_COUNT; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= REG_COUNT) j = j - REG_COUNT;
      if (!found && pending[ADDR_W'(j)]) begin
        found = 1'b1;
        idx   = ADDR_W'(j);
      end
    end
  end

endmodule

// File: rtl/multibus_cfg_sequencer.sv
// Delivers changed multibus registers one at a time over a valid/ready port.
module multibus_cfg_sequencer
  import multibus_pkg::*;
#(
  parameter int REG_COUNT = MB_REG_COUNT,
  parameter int ADDR_W    = MB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_COUNT*32-1:0] regs_in,
  input  logic                    force_all,
  output logic                    cfg_valid,
  output logic [ADDR_W-1:0]       cfg_addr,
  output logic [31:0]             cfg_data,
  input  logic                    cfg_ready,
  output logic [REG_COUNT-1:0]    pending,
  output logic                    busy
);

  // Two capture stages; a word is trusted only when both stages agree,
  // which is safe because host writes to the bank are quasi-static.
  logic [REG_COUNT*32-1:0] s1, s2;
  logic [31:0]             s2_word [REG_COUNT];
  logic [31:0]             shadow  [REG_COUNT];
  logic [REG_COUNT-1:0]    force_pend;
  logic [REG_COUNT-1:0]    stable;
  logic [ADDR_W-1:0]       ptr;
  logic [ADDR_W-1:0]       pick_idx;
  logic                    pick_found;
  logic                    load;
  logic                    ack;
  mb_state_e               state, state_nxt;

  // Capture pipeline from the FX2 clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so s2 takes the old s1.
      s1 <= regs_in;
      s2 <= s1;
    end
  end

  // Word view of s2, stability and needs-delivery flags.
  always_comb begin
    stable  = '0;
    pending = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      s2_word[i] = s2[i*32 +: 32];
      stable[i]  = (s1[i*32 +: 32] == s2[i*32 +: 32]);
      pending[i] = (stable[i] && (s2[i*32 +: 32] != shadow[i])) || force_pend[i];
    end
  end

  multibus_rr_pick #(
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  // Next-state decode plus the load/ack strobes for the datapath.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack       = 1'b0;
    unique case (state)
      SCAN: if (pick_found) begin
        load      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (cfg_ready) begin
        ack       = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // Offer register, shadow commit, rotation pointer and forced-resend flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid  <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      ptr        <= '0;
      force_pend <= '1;
      // NOTE: the shadow bank is reset because its zero contents define what counts as "changed".
      for (int i = 0; i < REG_COUNT; i++) shadow[i] <= '0;
    end else begin
      if (load) begin
        cfg_valid <= 1'b1;
        cfg_addr  <= pick_idx;
        cfg_data  <= s2_word[pick_idx];
      end
      if (ack) begin
        cfg_valid        <= 1'b0;
        shadow[cfg_addr] <= cfg_data;
        ptr              <= ADDR_W'(next_index(int'(cfg_addr), REG_COUNT));
      end
      // A resend request on the ack edge wins over the clear.
      if (force_all)  force_pend           <= '1;
      else if (ack)   force_pend[cfg_addr] <= 1'b0;
    end
  end

  assign busy = (state != SCAN);

endmodule
